rtm_c2d_dma: RTL and testbench
==============================

Name: rtm_c2d_dma

Overview:
Chip-to-DRAM transfer engine. Reads consecutive RTM rows and writes them to DRAM through an AXI4 master write channel. Started by the host control-register block with command registers 43 (n_bytes), 44 (c_addr) and 45 (d_addr), and a 0→1 edge on register 46 bit0. Raises irq source 2 on completion; the host clears it by writing 0x00040004 to register 0.

Parameters:
ROW_BYTES, 64, RTM row width in bytes (S*R); equals AXI data width/8
RTM_AW, 16, RTM row address width
RTM_RD_LAT, 2, fixed RTM read latency in cycles
MAX_BURST, 16, max beats per AXI burst
FIFO_DEPTH, 32, prefetch row buffer depth
MAX_OUTS, 4, max outstanding AW bursts without B response

Ports:
main_clk  in  1  clock
main_rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse (edge of reg46 bit0)
d_addr  in  32  DRAM byte address; bits[5:0] forced to 0
c_addr  in  RTM_AW  first RTM row address
n_bytes  in  32  transfer size; bits[5:0] ignored
busy  out  1  high from accepted start until done
irq  out  1  level completion interrupt
irq_clr  in  1  one-cycle clear pulse
err  out  1  sticky: a non-OKAY bresp was seen; cleared by start
rtm_rd_en  out  1  RTM read strobe
rtm_rd_addr  out  RTM_AW  RTM row address
rtm_rd_data  in  ROW_BYTES*8  row data, valid RTM_RD_LAT cycles after rtm_rd_en
m_awaddr/awlen[7:0]/awsize[2:0]/awburst[1:0]/awvalid  out  AW channel
m_awready  in  1
m_wdata[ROW_BYTES*8]/wstrb/wlast/wvalid  out  W channel
m_wready  in  1
m_bresp[1:0]/m_bvalid  in; m_bready  out  B channel

Behaviour:
- Reset values: busy=0, irq=0, err=0, rtm_rd_en=0, awvalid=0, wvalid=0, wlast=0, bready=0. All counters and the FIFO are cleared.
- Fixed fields: awsize=6 (64 B), awburst=INCR, wstrb all ones.
- Latch on start (IDLE only):
  - rows = n_bytes>>6
  - dptr = {d_addr[31:6],6'b0}
  - cptr = c_addr
  - err cleared
  - start while busy is ignored.
- States:
  - IDLE: start with rows==0 → DONE; start with rows>0 → RUN.
  - RUN: issue bursts until all rows have an AW → DRAIN.
  - DRAIN: wait until all W beats are sent and all B responses received → DONE.
  - DONE: one cycle; sets irq=1 and busy=0 → IDLE.
- Burst sizing: len = min(rows_left_aw, MAX_BURST, (4096 - dptr[11:0])>>6). A burst never crosses a 4 KB boundary. awlen = len-1. dptr advances by len*64.
- AW issue: only when outstanding AW count < MAX_OUTS. The count increments on AW handshake and decrements on B handshake. Signals hold stable until awready.
- RTM read side:
  - rtm_rd_en issued when fifo_count + inflight_reads < FIFO_DEPTH and rows remain to read.
  - rtm_rd_addr = cptr, incrementing by 1 per read and wrapping modulo 2^RTM_AW.
  - Return data is pushed into the FIFO after RTM_RD_LAT cycles. The FIFO never overflows.
- W side:
  - wvalid = FIFO non-empty and a burst has an AW already issued whose data is pending (burst-length queue, depth MAX_OUTS). W may not precede its AW.
  - wlast is asserted on the last beat of each burst.
  - Data is popped on wvalid&&wready. wdata holds stable while wvalid && !wready.
  - Byte j of a row maps to wdata[8j+:8]; DRAM byte d_addr+64i+j = row (c_addr+i) byte j.
- bready is held 1 while busy.
- bresp≠0 sets err. The transfer still completes and raises irq.
- irq: set in DONE, cleared by irq_clr. If set and clear occur in the same cycle, set wins. irq stays high across a new start until cleared.
- Throughput: with awready=wready=1, one W beat per cycle in steady state.
- Latency: the first rtm_rd_en occurs the cycle after start; the first awvalid also occurs the cycle after start.
- Reset mid-transfer returns immediately to IDLE with all outputs at reset values. The AXI interconnect must be reset together with this block.

Test Plan:
- d_addr=0x80000000, c_addr=0x8000, n_bytes=128 → one AW, awlen=1, two W beats, wlast on beat 2. DRAM matches RTM rows 0x8000–0x8001. irq=1; irq_clr → irq=0.
- n_bytes=256 → one AW, awlen=3 at 0x80000000. n_bytes=65536 → 64 bursts of awlen=15 at 1 KB steps, rows 0x8000–0x83FF, data checker reports 0 mismatches.
- d_addr=0x80000F80, n_bytes=256 → AW 0x80000F80 with awlen=1, then AW 0x80001000 with awlen=1. No burst crosses 4 KB.
- Random awready/wready/bvalid backpressure (≈50%) with n_bytes=65536 → data intact, never more than 4 outstanding AWs, FIFO never overflows, wdata stable under stall.
- n_bytes=0 → irq within 2 cycles, no AXI or RTM traffic. n_bytes=100 → exactly 1 row transferred.
- bresp=SLVERR on the 2nd burst → err=1 and irq still raised; the next start clears err. Reset asserted mid-transfer → busy=0, awvalid=0, wvalid=0 at once, and a new start afterwards succeeds.

Source files
------------

// File: rtl/rtm_c2d_dma.sv
// rtm_c2d_dma: chip-to-DRAM engine; streams consecutive RTM rows into DRAM
// through an AXI4 write master (AW/W/B), with a prefetch row FIFO.
// Ports: main_clk/main_rst; start/d_addr/c_addr/n_bytes command inputs;
//   busy/irq/irq_clr/err status; rtm_rd_* RTM read port; m_aw*/m_w*/m_b* AXI.
module rtm_c2d_dma #(
   parameter int ROW_BYTES  = 64,
   parameter int RTM_AW     = 16,
   parameter int RTM_RD_LAT = 2,
   parameter int MAX_BURST  = 16,
   parameter int FIFO_DEPTH = 32,
   parameter int MAX_OUTS   = 4
) (
   input  logic                   main_clk,
   input  logic                   main_rst,
   input  logic                   start,
   input  logic [31:0]            d_addr,
   input  logic [RTM_AW-1:0]      c_addr,
   input  logic [31:0]            n_bytes,
   output logic                   busy,
   output logic                   irq,
   input  logic                   irq_clr,
   output logic                   err,
   output logic                   rtm_rd_en,
   output logic [RTM_AW-1:0]      rtm_rd_addr,
   input  logic [ROW_BYTES*8-1:0] rtm_rd_data,
   output logic [31:0]            m_awaddr,
   output logic [7:0]             m_awlen,
   output logic [2:0]             m_awsize,
   output logic [1:0]             m_awburst,
   output logic                   m_awvalid,
   input  logic                   m_awready,
   output logic [ROW_BYTES*8-1:0] m_wdata,
   output logic [ROW_BYTES-1:0]   m_wstrb,
   output logic                   m_wlast,
   output logic                   m_wvalid,
   input  logic                   m_wready,
   input  logic [1:0]             m_bresp,
   input  logic                   m_bvalid,
   output logic                   m_bready
);

   localparam int DW  = ROW_BYTES * 8;
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int QAW = $clog2(MAX_OUTS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic              awvalid_q, awvalid_d;
   logic [31:0]       awaddr_q, awaddr_d;
   logic [7:0]        awlen_q, awlen_d;
   logic [31:0]       dptr_q, dptr_d;
   logic [25:0]       rows_aw_q, rows_aw_d;
   logic [25:0]       rows_rd_q, rows_rd_d;
   logic              rd_en_q, rd_en_d;
   logic [RTM_AW-1:0] rd_addr_q, rd_addr_d;
   logic [RTM_RD_LAT-1:0] pipe_q, pipe_d;
   logic [QAW:0]      outs_q, outs_d;
   logic              irq_q, irq_d;
   logic              err_q, err_d;

   logic [FAW-1:0]    fwr_q, fwr_d, frd_q, frd_d;
   logic [FAW:0]      fcnt_q, fcnt_d;
   logic [DW-1:0]     fifo_mem [FIFO_DEPTH];

   logic [QAW-1:0]    bwr_q, bwr_d, brd_q, brd_d;
   logic [QAW:0]      bcnt_q, bcnt_d;
   logic [7:0]        beat_q, beat_d;
   logic [7:0]        blq_mem [MAX_OUTS];

   logic        aw_hs, w_hs, b_hs, aw_free, aw_issue;
   logic        push, pop_last;
   logic [25:0] rows_in, rows_src;
   logic [31:0] dptr_in, dptr_src;
   logic [6:0]  room;
   logic [8:0]  len;
   logic [15:0] occ;
   logic        unused_low;

   assign unused_low = ^{d_addr[5:0], n_bytes[5:0]};

   assign rows_in = n_bytes[31:6];
   assign dptr_in = {d_addr[31:6], 6'b0};

   assign busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign m_bready = busy;
   assign irq      = irq_q;
   assign err      = err_q;

   assign rtm_rd_en   = rd_en_q;
   assign rtm_rd_addr = rd_addr_q;

   assign m_awaddr  = awaddr_q;
   assign m_awlen   = awlen_q;
   assign m_awsize  = 3'd6;
   assign m_awburst = 2'b01;
   assign m_awvalid = awvalid_q;

   // W only runs when a burst has its AW accepted and a row is buffered.
   assign m_wvalid = (fcnt_q != '0) && (bcnt_q != '0);
   assign m_wlast  = m_wvalid && (beat_q == blq_mem[brd_q]);
   assign m_wdata  = fifo_mem[frd_q];
   assign m_wstrb  = '1;

   assign aw_hs    = awvalid_q && m_awready;
   assign w_hs     = m_wvalid && m_wready;
   assign b_hs     = m_bvalid && m_bready;
   assign aw_free  = !awvalid_q || m_awready;
   assign push     = pipe_q[RTM_RD_LAT-1];
   assign pop_last = w_hs && m_wlast;

   // The first burst is sized from the command inputs so AW can go out
   // the cycle after start.
   assign rows_src = (state_q == S_IDLE) ? rows_in : rows_aw_q;
   assign dptr_src = (state_q == S_IDLE) ? dptr_in : dptr_q;
   assign room     = 7'd64 - {1'b0, dptr_src[11:6]};

   always_comb begin
      len = 9'(MAX_BURST);
      if ({2'b0, room} < len) len = {2'b0, room};
      if (rows_src < 26'(len)) len = rows_src[8:0];
   end

   // Rows buffered plus reads still in the RTM pipe.
   always_comb begin
      occ = 16'(fcnt_q) + 16'(rd_en_q);
      for (int k = 0; k < RTM_RD_LAT; k++) occ = occ + 16'(pipe_q[k]);
   end

   assign outs_d = outs_q + (QAW+1)'(aw_hs) - (QAW+1)'(b_hs);

   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      awaddr_d  = awaddr_q;
      awlen_d   = awlen_q;
      dptr_d    = dptr_q;
      rows_aw_d = rows_aw_q;
      rows_rd_d = rows_rd_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      err_d     = err_q;
      irq_d     = irq_q;
      aw_issue  = 1'b0;
      if (aw_hs) awvalid_d = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               dptr_d    = dptr_in;
               rows_aw_d = rows_in;
               err_d     = 1'b0;
               if (rows_in == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_RUN;
                  aw_issue  = 1'b1;
                  rd_en_d   = 1'b1;
                  rd_addr_d = c_addr;
                  rows_rd_d = rows_in - 26'd1;
               end
            end
         end
         S_RUN: begin
            if (aw_free && rows_aw_q != '0 &&
                outs_d < (QAW+1)'(MAX_OUTS))
               aw_issue = 1'b1;
            if (rows_aw_q == '0 && aw_free) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (bcnt_q == '0 && outs_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (aw_issue) begin
         awvalid_d = 1'b1;
         awaddr_d  = dptr_src;
         awlen_d   = 8'(len - 9'd1);
         dptr_d    = dptr_src + (32'(len) << 6);
         rows_aw_d = rows_src - 26'(len);
      end
      if (busy && rows_rd_q != '0 && occ < 16'(FIFO_DEPTH)) begin
         rd_en_d   = 1'b1;
         rd_addr_d = rd_addr_q + 1'b1;
         rows_rd_d = rows_rd_q - 26'd1;
      end
      if (b_hs && m_bresp != 2'b00) err_d = 1'b1;
      if (irq_clr) irq_d = 1'b0;
      if (state_q == S_DONE) irq_d = 1'b1;
   end

   always_comb begin
      pipe_d = RTM_RD_LAT'({pipe_q, rd_en_q});
      fwr_d  = push ? fwr_q + 1'b1 : fwr_q;
      frd_d  = w_hs ? frd_q + 1'b1 : frd_q;
      fcnt_d = fcnt_q + (FAW+1)'(push) - (FAW+1)'(w_hs);
      bwr_d  = aw_hs ? bwr_q + 1'b1 : bwr_q;
      brd_d  = pop_last ? brd_q + 1'b1 : brd_q;
      bcnt_d = bcnt_q + (QAW+1)'(aw_hs) - (QAW+1)'(pop_last);
      beat_d = beat_q;
      if (w_hs) beat_d = m_wlast ? 8'd0 : beat_q + 8'd1;
   end

   always_ff @(posedge main_clk or posedge main_rst) begin
      if (main_rst) begin
         state_q   <= S_IDLE;
         awvalid_q <= 1'b0;
         awaddr_q  <= '0;
         awlen_q   <= '0;
         dptr_q    <= '0;
         rows_aw_q <= '0;
         rows_rd_q <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         pipe_q    <= '0;
         outs_q    <= '0;
         irq_q     <= 1'b0;
         err_q     <= 1'b0;
         fwr_q     <= '0;
         frd_q     <= '0;
         fcnt_q    <= '0;
         bwr_q     <= '0;
         brd_q     <= '0;
         bcnt_q    <= '0;
         beat_q    <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         awaddr_q  <= awaddr_d;
         awlen_q   <= awlen_d;
         dptr_q    <= dptr_d;
         rows_aw_q <= rows_aw_d;
         rows_rd_q <= rows_rd_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         pipe_q    <= pipe_d;
         outs_q    <= outs_d;
         irq_q     <= irq_d;
         err_q     <= err_d;
         fwr_q     <= fwr_d;
         frd_q     <= frd_d;
         fcnt_q    <= fcnt_d;
         bwr_q     <= bwr_d;
         brd_q     <= brd_d;
         bcnt_q    <= bcnt_d;
         beat_q    <= beat_d;
      end
   end

   always_ff @(posedge main_clk) begin
      if (push) fifo_mem[fwr_q] <= rtm_rd_data;
      if (aw_hs) blq_mem[bwr_q] <= awlen_q;
   end

endmodule

// File: tb/tb_rtm_c2d_dma.sv
// tb_rtm_c2d_dma: RTM/AXI slave models plus a byte-level DRAM image
// compared against expected rows and burst lists computed arithmetically.
module tb_rtm_c2d_dma;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   logic         main_clk = 1'b0;
   logic         main_rst = 1'b1;
   logic         start = 1'b0;
   logic [31:0]  d_addr = '0;
   logic [15:0]  c_addr = '0;
   logic [31:0]  n_bytes = '0;
   logic         busy, irq, err;
   logic         irq_clr = 1'b0;
   logic         rtm_rd_en;
   logic [15:0]  rtm_rd_addr;
   logic [511:0] rtm_rd_data;
   logic [31:0]  m_awaddr;
   logic [7:0]   m_awlen;
   logic [2:0]   m_awsize;
   logic [1:0]   m_awburst;
   logic         m_awvalid, m_awready;
   logic [511:0] m_wdata;
   logic [63:0]  m_wstrb;
   logic         m_wlast, m_wvalid, m_wready;
   logic [1:0]   m_bresp;
   logic         m_bvalid, m_bready;

   always #5 main_clk = ~main_clk;

   rtm_c2d_dma dut (
      .main_clk(main_clk), .main_rst(main_rst), .start(start),
      .d_addr(d_addr), .c_addr(c_addr), .n_bytes(n_bytes),
      .busy(busy), .irq(irq), .irq_clr(irq_clr), .err(err),
      .rtm_rd_en(rtm_rd_en), .rtm_rd_addr(rtm_rd_addr),
      .rtm_rd_data(rtm_rd_data),
      .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
      .m_awburst(m_awburst), .m_awvalid(m_awvalid),
      .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
      .m_wvalid(m_wvalid), .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
   );

   int checks = 0;
   int errors = 0;

   bit          bp = 1'b0;
   int          err_burst = -1;
   logic [31:0] salt = 32'h1234_5678;

   aw_t          aw_log[$];
   aw_t          wpend[$];
   logic [511:0] dram [int unsigned];
   int  beat = 0, b_pend = 0, b_idx = 0;
   int  aw_acc = 0, b_done = 0, rd_cnt = 0, wbeats = 0, viol = 0;
   bit  rd_prev_en = 1'b0, out_en = 1'b0, bhs = 1'b0;
   logic [15:0] rd_prev_addr = '0, out_addr = '0;
   bit  aw_stall = 1'b0, w_stall = 1'b0;
   aw_t aw_prev;
   logic [511:0] w_prev;

   function automatic logic [511:0] rowdata(input logic [15:0] a);
      logic [511:0] r;
      for (int k = 0; k < 16; k++)
         r[32*k +: 32] = ({16'h0, a} * 32'h9E37_79B1) ^
                         (32'(k) * 32'h85EB_CA77) ^ salt;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // RTM read port, AXI write slave and protocol monitors.
   initial begin
      m_awready = 1'b0;
      m_wready  = 1'b0;
      m_bvalid  = 1'b0;
      m_bresp   = 2'b00;
      rtm_rd_data = '0;
      forever begin
         @(posedge main_clk);
         bhs = 1'b0;
         if (main_rst) begin
            wpend.delete();
            beat = 0; b_pend = 0;
            rd_prev_en = 1'b0; out_en = 1'b0;
            aw_stall = 1'b0; w_stall = 1'b0;
         end else begin
            if (start) begin
               aw_log.delete(); dram.delete();
               aw_acc = 0; b_done = 0; rd_cnt = 0;
               wbeats = 0; viol = 0; b_idx = 0;
            end
            out_en = rd_prev_en;
            out_addr = rd_prev_addr;
            rd_prev_en = rtm_rd_en;
            rd_prev_addr = rtm_rd_addr;
            if (rtm_rd_en) rd_cnt++;
            if (aw_stall && !(m_awvalid && m_awaddr === aw_prev.addr &&
                              m_awlen === aw_prev.len)) viol++;
            if (w_stall && !(m_wvalid && m_wdata === w_prev)) viol++;
            if (m_wvalid && wpend.size() == 0) viol++;
            if (m_wvalid && m_wready && wpend.size() != 0) begin
               dram[wpend[0].addr + 32'(64 * beat)] = m_wdata;
               wbeats++;
               if (m_wstrb !== '1) viol++;
               if (m_wlast !== (beat == int'(wpend[0].len))) viol++;
               if (beat == int'(wpend[0].len)) begin
                  void'(wpend.pop_front());
                  beat = 0;
                  b_pend++;
               end else beat++;
            end
            if (m_awvalid && m_awready) begin
               aw_log.push_back({m_awaddr, m_awlen});
               wpend.push_back({m_awaddr, m_awlen});
               aw_acc++;
               if (m_awsize !== 3'd6 || m_awburst !== 2'b01) viol++;
               if (int'(m_awaddr[11:0]) + 64 * (int'(m_awlen) + 1) > 4096)
                  viol++;
            end
            if (m_bvalid && m_bready) begin
               b_done++;
               b_pend--;
               bhs = 1'b1;
            end
            if (aw_acc - b_done > 4) viol++;
            if (rd_cnt - wbeats > 32) viol++;
            aw_stall = m_awvalid && !m_awready;
            aw_prev = {m_awaddr, m_awlen};
            w_stall = m_wvalid && !m_wready;
            w_prev = m_wdata;
         end
         #1;
         if (out_en) rtm_rd_data = rowdata(out_addr);
         else for (int k = 0; k < 16; k++) rtm_rd_data[32*k +: 32] = $urandom;
         m_awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         m_wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (main_rst || bhs) m_bvalid = 1'b0;
         if (!main_rst && !m_bvalid && b_pend > 0 &&
             (!bp || $urandom_range(0, 1) == 1)) begin
            m_bvalid = 1'b1;
            m_bresp = (b_idx == err_burst) ? 2'b10 : 2'b00;
            b_idx++;
         end
      end
   end

   task automatic step();
      @(posedge main_clk);
      #1;
   endtask

   task automatic run(input logic [31:0] d, input logic [15:0] c,
                      input logic [31:0] n, input bit bpv, input int errb);
      int rows, rem, len, awm, mism, cyc;
      logic [31:0] a;
      aw_t exp_aw[$];
      bp = bpv;
      err_burst = errb;
      salt = $urandom;
      rows = int'(n >> 6);
      if (irq) begin
         irq_clr = 1'b1;
         step();
         irq_clr = 1'b0;
         chk("irq_clr", irq, 0);
      end
      d_addr = d; c_addr = c; n_bytes = n;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("err_cleared", err, 0);
      if (rows > 0) begin
         chk("rd_latency", rtm_rd_en, 1);
         chk("aw_latency", m_awvalid, 1);
         chk("busy_run", busy, 1);
      end
      cyc = 0;
      while (!irq && cyc < 20000) begin
         step();
         cyc++;
      end
      chk("done_irq", irq, 1);
      if (rows == 0) chk("irq_latency", cyc < 2, 1);
      chk("busy_end", busy, 0);
      a = d & 32'hFFFF_FFC0;
      rem = rows;
      while (rem > 0) begin
         len = rem;
         if (len > 16) len = 16;
         if (len > (4096 - int'(a % 4096)) / 64)
            len = (4096 - int'(a % 4096)) / 64;
         exp_aw.push_back({a, 8'(len - 1)});
         a += 32'(len * 64);
         rem -= len;
      end
      chk("aw_count", aw_log.size(), exp_aw.size());
      awm = 0;
      foreach (exp_aw[i])
         if (i >= aw_log.size() || aw_log[i] !== exp_aw[i]) awm++;
      chk("aw_fields", awm, 0);
      mism = 0;
      for (int i = 0; i < rows; i++) begin
         a = (d & 32'hFFFF_FFC0) + 32'(64 * i);
         if (!dram.exists(a) || dram[a] !== rowdata(16'(int'(c) + i)))
            mism++;
      end
      chk("data", mism, 0);
      chk("dram_rows", dram.num(), rows);
      chk("w_beats", wbeats, rows);
      chk("rtm_reads", rd_cnt, rows);
      chk("protocol", viol, 0);
      chk("err", err, (errb >= 0 && errb < exp_aw.size()) ? 1 : 0);
   endtask

   initial begin
      logic [31:0] rd, rn;
      logic [15:0] rc;
      repeat (3) @(posedge main_clk);
      #1;
      main_rst = 1'b0;
      @(negedge main_clk);
      chk("reset", {busy, irq, err, rtm_rd_en, m_awvalid,
                    m_wvalid, m_wlast, m_bready}, 0);
      step();

      run(32'h8000_0000, 16'h8000, 32'd128, 1'b0, -1);
      run(32'h8000_0000, 16'h8000, 32'd256, 1'b0, -1);
      run(32'h8000_0000, 16'h8000, 32'd65536, 1'b0, -1);
      run(32'h8000_0F80, 16'h8000, 32'd256, 1'b0, -1);
      run(32'h8000_0000, 16'h8000, 32'd65536, 1'b1, -1);
      run(32'h8000_0000, 16'h8000, 32'd0, 1'b0, -1);
      run(32'h8000_0000, 16'h8000, 32'd100, 1'b0, -1);

      // Completion and clear in the same cycle: the set wins.
      start = 1'b1;
      n_bytes = 32'd0;
      step();
      start = 1'b0;
      irq_clr = 1'b1;
      step();
      irq_clr = 1'b0;
      chk("irq_set_wins", irq, 1);

      run(32'h8000_0000, 16'h0100, 32'd4096, 1'b0, 1);
      run(32'h8000_2000, 16'h0200, 32'd1024, 1'b1, -1);

      // Reset in the middle of a long transfer.
      bp = 1'b1;
      d_addr = 32'h8000_0000; c_addr = 16'h8000; n_bytes = 32'd65536;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (60) step();
      #2 main_rst = 1'b1;
      #1;
      chk("mid_reset", {busy, irq, err, rtm_rd_en, m_awvalid,
                        m_wvalid, m_wlast, m_bready}, 0);
      step();
      main_rst = 1'b0;
      step();
      run(32'h8000_0000, 16'h8000, 32'd512, 1'b1, -1);

      for (int t = 0; t < 3; t++) begin
         rd = 32'h8000_0000 + (32'($urandom_range(0, 4095)) << 6) +
              32'($urandom_range(0, 63));
         rc = (t == 0) ? 16'hFFF0 : 16'($urandom);
         rn = 32'($urandom_range(0, 8191));
         run(rd, rc, rn, 1'b1, -1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
